// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the cache arbiter: FSM states, the latched
// request bundle, default sizes, and a small modular-increment helper.
package cache_arb_pkg;

  localparam int ADDR_SIZE       = 16;
  localparam int TIMEOUT_DEFAULT = 1024;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2,
    RESPOND = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic                 write;
    logic                 wthru;
    logic                 rthru;
    logic [ADDR_SIZE-1:0] addr;
    logic [31:0]          wdata;
  } arb_req_t;

  function automatic int wrap_inc(input int value, input int modulus);
    return (value + 1) % modulus;
  endfunction

endpackage

// File: rtl/cache_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set request bit at or
// above ptr, wrapping around to bit 0.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               grant_valid,
  output logic [ID_W-1:0]    grant_idx
);

  // Scan offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      int j;
      j           = (int'(ptr) + i) % NUM_REQ;
      grant_valid = grant_valid | req[j];
      grant_idx   = req[j] ? ID_W'(j) : grant_idx;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one cache among NUM_REQ requesters; drives the
// cache's level-sensitive enable/done handshake and pulses req_done per request.
module cache_arbiter
  import cache_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = ADDR_SIZE,
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ-1:0]             req_wthru,
  input  logic [NUM_REQ-1:0]             req_rthru,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0][31:0]       req_wdata,
  output logic [NUM_REQ-1:0]             req_done,
  output logic [31:0]                    req_rdata,
  output logic [ID_W-1:0]                grant_id,
  output logic                           busy,
  output logic                           timeout_err,
  output logic                           c_w_en,
  output logic                           c_r_en,
  output logic                           c_write_through,
  output logic                           c_read_through,
  output logic [ADDR_W-1:0]              c_addr,
  output logic [31:0]                    c_data_store,
  input  logic [31:0]                    c_data_load,
  input  logic                           c_done
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  arb_state_t           state, state_nx;
  logic [ID_W-1:0]      rr_ptr, rr_ptr_nx;
  logic [CNT_W-1:0]     cnt, cnt_nx;
  logic [31:0]          rdata_cap, rdata_cap_nx;
  logic [NUM_REQ-1:0]   req_done_nx;
  logic [31:0]          req_rdata_nx;
  logic [ID_W-1:0]      grant_id_nx;
  logic                 busy_nx, timeout_err_nx;
  logic                 c_w_en_nx, c_r_en_nx, c_wthru_nx, c_rthru_nx;
  logic [ADDR_W-1:0]    c_addr_nx;
  logic [31:0]          c_data_store_nx;
  logic                 grant_valid;
  logic [ID_W-1:0]      grant_idx;
  logic                 at_limit;
  arb_req_t             sel;

  rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req         (req_valid),
    .ptr         (rr_ptr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Bundle the candidate winner's request fields.
  always_comb begin
    sel.write = req_write[grant_idx];
    sel.wthru = req_wthru[grant_idx];
    sel.rthru = req_rthru[grant_idx];
    sel.addr  = ADDR_SIZE'(req_addr[grant_idx]);
    sel.wdata = req_wdata[grant_idx];
  end

  assign at_limit = (cnt == CNT_W'(TIMEOUT - 1));

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nx        = state;
    rr_ptr_nx       = rr_ptr;
    cnt_nx          = cnt;
    rdata_cap_nx    = rdata_cap;
    req_done_nx     = '0;
    req_rdata_nx    = req_rdata;
    grant_id_nx     = grant_id;
    timeout_err_nx  = timeout_err;
    c_w_en_nx       = c_w_en;
    c_r_en_nx       = c_r_en;
    c_wthru_nx      = c_write_through;
    c_rthru_nx      = c_read_through;
    c_addr_nx       = c_addr;
    c_data_store_nx = c_data_store;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          c_w_en_nx       = sel.write;
          c_r_en_nx       = ~sel.write;
          c_wthru_nx      = sel.wthru;
          c_rthru_nx      = sel.rthru;
          c_addr_nx       = ADDR_W'(sel.addr);
          c_data_store_nx = sel.wdata;
          grant_id_nx     = grant_idx;
          rr_ptr_nx       = ID_W'(wrap_inc(int'(grant_idx), NUM_REQ));
          cnt_nx          = '0;
          state_nx        = ISSUE;
        end else begin
          state_nx = IDLE;
        end
      end
      ISSUE: begin
        cnt_nx         = at_limit ? cnt : cnt + CNT_W'(1);
        timeout_err_nx = timeout_err | at_limit;
        if (c_done) begin
          rdata_cap_nx    = c_data_load;
          c_w_en_nx       = 1'b0;
          c_r_en_nx       = 1'b0;
          c_wthru_nx      = 1'b0;
          c_rthru_nx      = 1'b0;
          c_addr_nx       = '0;
          state_nx        = RELEASE;
        end else begin
          state_nx = ISSUE;
        end
      end
      RELEASE: begin
        cnt_nx         = at_limit ? cnt : cnt + CNT_W'(1);
        timeout_err_nx = timeout_err | at_limit;
        // The pulse is launched here so it is visible during RESPOND itself.
        if (!c_done) begin
          req_done_nx  = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;
          req_rdata_nx = rdata_cap;
          state_nx     = RESPOND;
        end else begin
          state_nx = RELEASE;
        end
      end
      RESPOND: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    busy_nx = (state_nx != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      cnt             <= '0;
      rdata_cap       <= 32'h0;
      req_done        <= '0;
      req_rdata       <= 32'h0;
      grant_id        <= '0;
      busy            <= 1'b0;
      timeout_err     <= 1'b0;
      c_w_en          <= 1'b0;
      c_r_en          <= 1'b0;
      c_write_through <= 1'b0;
      c_read_through  <= 1'b0;
      c_addr          <= '0;
      c_data_store    <= 32'h0;
    end else begin
      state           <= state_nx;
      rr_ptr          <= rr_ptr_nx;
      cnt             <= cnt_nx;
      rdata_cap       <= rdata_cap_nx;
      req_done        <= req_done_nx;
      req_rdata       <= req_rdata_nx;
      grant_id        <= grant_id_nx;
      busy            <= busy_nx;
      timeout_err     <= timeout_err_nx;
      c_w_en          <= c_w_en_nx;
      c_r_en          <= c_r_en_nx;
      c_write_through <= c_wthru_nx;
      c_read_through  <= c_rthru_nx;
      c_addr          <= c_addr_nx;
      c_data_store    <= c_data_store_nx;
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter with a small behavioural cache model
// (fixed 3-cycle latency, level done held until the enables drop).
module tb_cache_arbiter;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       req_valid, req_write, req_wthru, req_rthru;
  logic [3:0][15:0] req_addr;
  logic [3:0][31:0] req_wdata;
  logic [3:0]       req_done;
  logic [31:0]      req_rdata;
  logic [1:0]       grant_id;
  logic             busy, timeout_err;
  logic             c_w_en, c_r_en, c_write_through, c_read_through;
  logic [15:0]      c_addr;
  logic [31:0]      c_data_store, c_data_load;
  logic             c_done;

  logic             stall, hold_done;
  logic [31:0]      mem [0:255];
  logic [1:0]       lat;

  int n_pass  = 0;
  int n_total = 0;

  cache_arbiter #(.NUM_REQ(4), .ADDR_W(16), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_wthru(req_wthru),
    .req_rthru(req_rthru), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_done(req_done), .req_rdata(req_rdata), .grant_id(grant_id),
    .busy(busy), .timeout_err(timeout_err),
    .c_w_en(c_w_en), .c_r_en(c_r_en), .c_write_through(c_write_through),
    .c_read_through(c_read_through), .c_addr(c_addr),
    .c_data_store(c_data_store), .c_data_load(c_data_load), .c_done(c_done)
  );

  always #5 clk = ~clk;

  // Cache model: done rises 3 cycles after an enable, falls a cycle after enables drop.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      c_done      <= 1'b0;
      lat         <= 2'd0;
      c_data_load <= 32'h0;
      mem[8'h10]  <= 32'hDEADBEEF;
    end else if ((c_w_en || c_r_en) && !stall && !c_done) begin
      if (lat == 2'd2) begin
        c_done <= 1'b1;
        lat    <= 2'd0;
        if (c_w_en) mem[c_addr[7:0]] <= c_data_store;
        else        c_data_load      <= mem[c_addr[7:0]];
      end else begin
        lat <= lat + 2'd1;
      end
    end else if (!(c_w_en || c_r_en) && !hold_done) begin
      c_done <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic issue(input int idx, input logic wr, input logic [15:0] addr, input logic [31:0] wd);
    req_valid[idx] = 1'b1;
    req_write[idx] = wr;
    req_addr[idx]  = addr;
    req_wdata[idx] = wd;
  endtask

  task automatic wait_done(input int idx, input bit drop, output logic [31:0] rd, output int cyc);
    bit seen;
    seen = 1'b0;
    rd   = 32'h0;
    cyc  = 0;
    for (int k = 1; k <= 100 && !seen; k++) begin
      @(negedge clk);
      if (req_done != 4'b0000) begin
        seen = 1'b1;
        cyc  = k;
        check("done_onehot", 64'(req_done), 64'(4'b0001 << idx));
        rd = req_rdata;
        if (drop) req_valid[idx] = 1'b0;
      end
    end
    if (!seen) check("done_timeout", 64'd0, 64'd1);
    else begin
      @(negedge clk);
      check("done_pulse", 64'(req_done), 64'd0);
    end
  endtask

  initial begin
    logic [31:0] rd;
    int          cyc;
    int          pulses;
    rst = 1'b1; stall = 1'b0; hold_done = 1'b0;
    req_valid = 4'b0; req_write = 4'b0; req_wthru = 4'b0; req_rthru = 4'b0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_ctl", 64'({busy, grant_id, req_done, c_w_en, c_r_en, timeout_err, c_write_through}), 64'd0);
    check("reset_data", 64'({req_rdata, c_data_store}), 64'd0);
    check("reset_addr", 64'(c_addr), 64'd0);

    // Single read by requester 2.
    issue(2, 1'b0, 16'h0010, 32'h0);
    @(negedge clk);
    check("rd_en", 64'({c_r_en, c_w_en, busy}), 64'b101);
    check("rd_grant", 64'(grant_id), 64'd2);
    check("rd_addr", 64'(c_addr), 64'h10);
    wait_done(2, 1'b1, rd, cyc);
    check("rd_data", 64'(rd), 64'hDEADBEEF);
    check("rd_latency", 64'(cyc), 64'd6);

    // Write-through store by requester 0, with step-by-step handshake checks.
    req_wthru[0] = 1'b1;
    issue(0, 1'b1, 16'h0020, 32'h12345678);
    @(negedge clk);
    check("wr_en", 64'({c_w_en, c_r_en, c_write_through}), 64'b101);
    check("wr_store", 64'(c_data_store), 64'h12345678);
    for (int k = 0; k < 20 && !c_done; k++) @(negedge clk);
    check("wr_wen_held", 64'({c_done, c_w_en}), 64'b11);
    @(negedge clk);
    check("wr_wen_drop", 64'({c_done, c_w_en, c_write_through, busy}), 64'b1001);
    @(negedge clk);
    check("wr_done_wait", 64'({c_done, req_done}), 64'd0);
    @(negedge clk);
    check("wr_done_pulse", 64'(req_done), 64'b0001);
    req_valid[0] = 1'b0;
    req_wthru[0] = 1'b0;
    @(negedge clk);
    check("wr_idle", 64'({busy, req_done}), 64'd0);
    issue(0, 1'b0, 16'h0020, 32'h0);
    wait_done(0, 1'b1, rd, cyc);
    check("wr_readback", 64'(rd), 64'h12345678);

    // Fairness: all four held valid from rr_ptr = 0.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) issue(i, 1'b0, 16'h0010, 32'h0);
    for (int n = 0; n < 5; n++) begin
      wait_done(n % 4, (n == 4), rd, cyc);
    end
    req_valid = 4'b0;

    // Requester 1 drops valid mid-ISSUE; the write still completes once.
    issue(1, 1'b1, 16'h0030, 32'hA5A5A5A5);
    @(negedge clk);
    check("drop_grant", 64'({grant_id, c_w_en}), 64'b011);
    req_valid[1] = 1'b0;
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (req_done == 4'b0010) pulses++;
    end
    check("drop_pulses", 64'(pulses), 64'd1);
    issue(1, 1'b0, 16'h0030, 32'h0);
    wait_done(1, 1'b1, rd, cyc);
    check("drop_readback", 64'(rd), 64'hA5A5A5A5);

    // Timeout: cache never answers.
    stall = 1'b1;
    issue(0, 1'b0, 16'h0040, 32'h0);
    repeat (16) @(negedge clk);
    check("to_before", 64'(timeout_err), 64'd0);
    @(negedge clk);
    check("to_rise", 64'({timeout_err, busy, c_r_en}), 64'b111);
    repeat (10) @(negedge clk);
    check("to_sticky", 64'({timeout_err, busy}), 64'b11);
    rst = 1'b1;
    req_valid = 4'b0;
    stall = 1'b0;
    #1;
    check("to_rst", 64'({timeout_err, busy}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset during RELEASE, then a clean read by requester 3.
    hold_done = 1'b1;
    issue(2, 1'b0, 16'h0010, 32'h0);
    for (int k = 0; k < 30 && !(busy && !c_r_en && c_done); k++) @(negedge clk);
    check("rel_reached", 64'({busy, c_r_en, c_done}), 64'b101);
    rst = 1'b1;
    req_valid = 4'b0;
    #1;
    check("rel_rst_ctl", 64'({busy, grant_id, req_done, c_w_en, c_r_en, timeout_err}), 64'd0);
    check("rel_rst_data", 64'({req_rdata, c_data_store}), 64'd0);
    @(negedge clk);
    hold_done = 1'b0;
    rst = 1'b0;
    issue(3, 1'b0, 16'h0020, 32'h0);
    @(negedge clk);
    check("post_grant", 64'({grant_id, c_r_en}), 64'b111);
    wait_done(3, 1'b1, rd, cyc);
    check("post_data", 64'(rd), 64'h12345678);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
